// File: rtl/key_pulse_gen.sv
// key_pulse_gen: turns raw active-low push-buttons into debounced pressed
// levels and one-cycle command strobes. Each key gets a two-flop synchroniser,
// a stable-count debouncer and a small FSM that produces the press pulse and,
// for the keys enabled in REPEAT_MASK, auto-repeat pulses while the key is held.
module key_pulse_gen #(
    parameter int                N_KEYS           = 4,
    parameter int                DEBOUNCE_CYC     = 20000,
    parameter int                REPEAT_DELAY_CYC = 600000,
    parameter int                REPEAT_RATE_CYC  = 150000,
    parameter logic [N_KEYS-1:0] REPEAT_MASK      = 4'b0011
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_KEYS-1:0] i_key_n,
    output logic [N_KEYS-1:0] o_level,
    output logic [N_KEYS-1:0] o_pulse
);

    // One counter width covers every timing parameter, with a spare bit so
    // the terminal compare never sits at the wrap point.
    localparam int MAX_AB  = (DEBOUNCE_CYC > REPEAT_DELAY_CYC) ? DEBOUNCE_CYC : REPEAT_DELAY_CYC;
    localparam int MAX_CYC = (MAX_AB > REPEAT_RATE_CYC) ? MAX_AB : REPEAT_RATE_CYC;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY_CYC - 1);
    localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE_CYC - 1);

    typedef enum logic [1:0] {
        S_RELEASED,
        S_HELD_DELAY,
        S_HELD_REPEAT,
        S_HELD
    } key_state_t;

    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sync2;

    // Two-flop synchroniser; resets to all-ones (released) so that coming out
    // of reset with a key held is treated as a fresh press, never a phantom.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= i_key_n;
            sync2 <= sync1;
        end
    end

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        logic          sync;
        logic [CW-1:0] dcnt;
        logic [CW-1:0] dcnt_nxt;
        logic          level_q;
        logic          level_nxt;
        logic [CW-1:0] rcnt;
        logic [CW-1:0] rcnt_nxt;
        logic          pulse_q;
        logic          pulse_nxt;
        key_state_t    state;
        key_state_t    state_nxt;

        assign sync       = ~sync2[k];
        assign o_level[k] = level_q;
        assign o_pulse[k] = pulse_q;

        // Debounce: count consecutive cycles the synced level differs from the
        // accepted level; accept the new level once the run is long enough.
        always_comb begin
            dcnt_nxt  = '0;
            level_nxt = level_q;
            if (sync != level_q) begin
                if (dcnt == DEB_LAST) begin
                    level_nxt = sync;
                end else begin
                    dcnt_nxt = dcnt + 1'b1;
                end
            end
        end

        // Key FSM looks at the level being accepted this cycle, so the press
        // pulse lands in the same cycle the new level first becomes visible.
        always_comb begin
            state_nxt = state;
            rcnt_nxt  = rcnt;
            pulse_nxt = 1'b0;
            case (state)
                S_RELEASED: begin
                    rcnt_nxt = '0;
                    if (level_nxt) begin
                        pulse_nxt = 1'b1;
                        state_nxt = REPEAT_MASK[k] ? S_HELD_DELAY : S_HELD;
                    end
                end
                S_HELD_DELAY: begin
                    if (!level_nxt) begin
                        rcnt_nxt  = '0;
                        state_nxt = S_RELEASED;
                    end else if (rcnt == DELAY_LAST) begin
                        rcnt_nxt  = '0;
                        pulse_nxt = 1'b1;
                        state_nxt = S_HELD_REPEAT;
                    end else begin
                        rcnt_nxt = rcnt + 1'b1;
                    end
                end
                S_HELD_REPEAT: begin
                    if (!level_nxt) begin
                        rcnt_nxt  = '0;
                        state_nxt = S_RELEASED;
                    end else if (rcnt == RATE_LAST) begin
                        rcnt_nxt  = '0;
                        pulse_nxt = 1'b1;
                    end else begin
                        rcnt_nxt = rcnt + 1'b1;
                    end
                end
                S_HELD: begin
                    rcnt_nxt = '0;
                    if (!level_nxt) begin
                        state_nxt = S_RELEASED;
                    end
                end
                default: begin
                    rcnt_nxt  = '0;
                    state_nxt = S_RELEASED;
                end
            endcase
        end

        // Per-key state register: debounce counter, accepted level, repeat
        // counter, FSM state and the registered strobe.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                dcnt    <= '0;
                level_q <= 1'b0;
                rcnt    <= '0;
                state   <= S_RELEASED;
                pulse_q <= 1'b0;
            end else begin
                dcnt    <= dcnt_nxt;
                level_q <= level_nxt;
                rcnt    <= rcnt_nxt;
                state   <= state_nxt;
                pulse_q <= pulse_nxt;
            end
        end
    end

endmodule

// File: tb/tb_key_pulse_gen.sv
// tb_key_pulse_gen: scoreboard bench for key_pulse_gen with short timing
// parameters. Expected pulses (edge number relative to the stimulus, bit
// pattern) are queued as each scenario is driven and matched by a monitor.
module tb_key_pulse_gen;

    logic       clk;
    logic       i_rst;
    logic [3:0] i_key_n;
    logic [3:0] o_level;
    logic [3:0] o_pulse;

    typedef struct {
        int         edge_n;
        logic [3:0] pulse;
    } exp_t;

    exp_t exp_q[$];
    int   edge_no;
    int   base;
    int   total;
    int   bad;

    key_pulse_gen #(
        .N_KEYS          (4),
        .DEBOUNCE_CYC    (4),
        .REPEAT_DELAY_CYC(10),
        .REPEAT_RATE_CYC (3),
        .REPEAT_MASK     (4'b0011)
    ) dut (
        .i_clk  (clk),
        .i_rst  (i_rst),
        .i_key_n(i_key_n),
        .o_level(o_level),
        .o_pulse(o_pulse)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rising-edge counter; edge n of a scenario is edge_no == base + n.
    always @(posedge clk) begin
        edge_no = edge_no + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] key_n, input logic rst);
        #1;
        i_key_n = key_n;
        i_rst   = rst;
    endtask

    task automatic expectPulse(input int e, input logic [3:0] p);
        exp_t item;
        item.edge_n = e;
        item.pulse  = p;
        exp_q.push_back(item);
    endtask

    task automatic waitTo(input int n);
        while (edge_no < base + n) @(negedge clk);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        checkOutput("pending pulses", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: every strobe seen must match the head of the expected queue.
    always @(negedge clk) begin
        exp_t e;
        if (o_pulse != 4'b0000) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected pulse", {28'b0, o_pulse}, 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("pulse edge", edge_no - base, e.edge_n);
                checkOutput("pulse bits", {28'b0, o_pulse}, {28'b0, e.pulse});
            end
        end
    end

    initial begin
        total   = 0;
        bad     = 0;
        edge_no = 0;
        base    = 0;
        i_rst   = 1'b1;
        i_key_n = 4'b0000;

        // Reset with every key pressed.
        repeat (3) @(negedge clk);
        checkOutput("reset level", {28'b0, o_level}, 0);
        checkOutput("reset pulse", {28'b0, o_pulse}, 0);
        applyStimulus(4'b0000, 1'b0);
        base = edge_no;
        expectPulse(6, 4'b1111);
        expectPulse(16, 4'b0011);
        expectPulse(19, 4'b0011);
        expectPulse(22, 4'b0011);
        expectPulse(25, 4'b0011);
        waitTo(5);
        checkOutput("post-reset level e5", {28'b0, o_level}, 0);
        waitTo(6);
        checkOutput("post-reset level e6", {28'b0, o_level}, 32'hF);
        waitTo(20);
        applyStimulus(4'b1111, 1'b0);
        waitTo(25);
        checkOutput("all held e25", {28'b0, o_level}, 32'hF);
        waitTo(26);
        checkOutput("all released e26", {28'b0, o_level}, 0);
        settle(30);

        // Clean select press for 20 cycles.
        applyStimulus(4'b0111, 1'b0);
        base = edge_no;
        expectPulse(6, 4'b1000);
        waitTo(5);
        checkOutput("select level e5", {31'b0, o_level[3]}, 0);
        waitTo(6);
        checkOutput("select level e6", {28'b0, o_level}, 32'h8);
        waitTo(20);
        applyStimulus(4'b1111, 1'b0);
        waitTo(25);
        checkOutput("select level e25", {31'b0, o_level[3]}, 1);
        waitTo(26);
        checkOutput("select level e26", {31'b0, o_level[3]}, 0);
        settle(30);

        // Bouncing back key: 2-cycle toggles for 12 cycles, then held low.
        base = edge_no;
        for (int i = 0; i < 6; i++) begin
            waitTo(2 * i);
            applyStimulus((i % 2 == 0) ? 4'b1011 : 4'b1111, 1'b0);
        end
        waitTo(12);
        applyStimulus(4'b1011, 1'b0);
        expectPulse(18, 4'b0100);
        for (int n = 4; n <= 16; n += 4) begin
            waitTo(n);
            checkOutput("bounce level low", {31'b0, o_level[2]}, 0);
        end
        waitTo(17);
        checkOutput("bounce level e17", {31'b0, o_level[2]}, 0);
        waitTo(18);
        checkOutput("bounce level e18", {31'b0, o_level[2]}, 1);
        waitTo(24);
        applyStimulus(4'b1111, 1'b0);
        waitTo(30);
        checkOutput("bounce release e30", {31'b0, o_level[2]}, 0);
        settle(30);

        // Auto-repeat on up, held for 30 cycles.
        applyStimulus(4'b1101, 1'b0);
        base = edge_no;
        expectPulse(6, 4'b0010);
        for (int e = 16; e <= 34; e += 3) expectPulse(e, 4'b0010);
        waitTo(30);
        applyStimulus(4'b1111, 1'b0);
        waitTo(35);
        checkOutput("up level e35", {31'b0, o_level[1]}, 1);
        waitTo(36);
        checkOutput("up level e36", {31'b0, o_level[1]}, 0);
        settle(30);

        // Up and select pressed together.
        applyStimulus(4'b0101, 1'b0);
        base = edge_no;
        expectPulse(6, 4'b1010);
        for (int e = 16; e <= 25; e += 3) expectPulse(e, 4'b0010);
        waitTo(6);
        checkOutput("combo level e6", {28'b0, o_level}, 32'hA);
        waitTo(20);
        applyStimulus(4'b1111, 1'b0);
        waitTo(26);
        checkOutput("combo level e26", {28'b0, o_level}, 0);
        settle(30);

        // Reset pulsed while down is held.
        applyStimulus(4'b1110, 1'b0);
        base = edge_no;
        expectPulse(6, 4'b0001);
        waitTo(12);
        checkOutput("down level e12", {28'b0, o_level}, 32'h1);
        applyStimulus(4'b1110, 1'b1);
        #1;
        checkOutput("midhold reset level", {28'b0, o_level}, 0);
        checkOutput("midhold reset pulse", {28'b0, o_pulse}, 0);
        @(negedge clk);
        applyStimulus(4'b1110, 1'b0);
        base = edge_no;
        expectPulse(6, 4'b0001);
        for (int e = 16; e <= 25; e += 3) expectPulse(e, 4'b0001);
        waitTo(5);
        checkOutput("re-press level e5", {28'b0, o_level}, 0);
        waitTo(6);
        checkOutput("re-press level e6", {28'b0, o_level}, 32'h1);
        waitTo(20);
        applyStimulus(4'b1111, 1'b0);
        waitTo(26);
        checkOutput("re-press release e26", {28'b0, o_level}, 0);
        settle(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
